// File: rtl/rasterizer_pkg.sv
// Shared types and constants for the rasterizer vertex buffer.
package rasterizer_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } vbuf_state_t;

  localparam int VBUF_ADDR_LSB     = 2;
  localparam int VBUF_READ_LATENCY = 2;
  localparam int VBUF_IDX_W        = 8;
  localparam int VBUF_ADDR_W       = 26;
  localparam logic [7:0] VBUF_ERR_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == VBUF_ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vertex_buffer_slave_if.sv
// Avalon-MM pipelined-read slave bus between the vertex-fetch master and the buffer.
interface vertex_buffer_slave_if;
  import rasterizer_pkg::*;

  logic [VBUF_ADDR_W-1:0] slave_address;
  logic                   slave_read;
  logic                   slave_write;
  logic [3:0]             slave_byteenable;
  logic [31:0]            slave_writedata;
  logic [31:0]            slave_readdata;
  logic                   slave_readdatavalid;
  logic                   slave_waitrequest;

  modport slave (
    input  slave_address, slave_read, slave_write, slave_byteenable, slave_writedata,
    output slave_readdata, slave_readdatavalid, slave_waitrequest
  );

  modport master (
    output slave_address, slave_read, slave_write, slave_byteenable, slave_writedata,
    input  slave_readdata, slave_readdatavalid, slave_waitrequest
  );

endinterface

// File: rtl/vertex_buffer_slave_ram.sv
// Simple dual-port byte-enabled vertex storage with a one-cycle registered read.
module vertex_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vertex_buffer_slave.sv
// Vertex buffer responder for the rasterizer vertex-fetch read master.
//   state | meaning
//   CLEAR | zero-fill sweep, one word per cycle, bus stalled
//   READY | accepting reads and writes
module vertex_buffer_slave
  import rasterizer_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  vertex_buffer_slave_if.slave  bus,
  input  logic                  clear_req,
  output logic [7:0]            error_count
);

  localparam logic [VBUF_IDX_W:0]   DEPTH_LIM = (VBUF_IDX_W+1)'(DEPTH_WORDS);
  localparam logic [VBUF_IDX_W-1:0] LAST_IDX  = VBUF_IDX_W'(DEPTH_WORDS - 1);

  vbuf_state_t           state_q, state_d;
  logic [VBUF_IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_ok_q, rd_ok_d;
  logic                  rdv_q, rdv_d;
  logic [31:0]           rdata_out_q, rdata_out_d;
  logic [7:0]            err_q, err_d;

  logic                  wait_req;
  logic                  clearing;
  logic [VBUF_IDX_W-1:0] word_idx;
  logic                  in_range;
  logic                  rd_acc, wr_acc;

  logic                  ram_we, ram_re;
  logic [VBUF_IDX_W-1:0] ram_waddr;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata, ram_rdata;
  logic                  unused_addr_bits;

  // Byte-lane bits are ignored: misaligned addresses land on the containing word.
  assign unused_addr_bits = ^bus.slave_address[VBUF_ADDR_LSB-1:0];

  assign word_idx = bus.slave_address[VBUF_ADDR_LSB +: VBUF_IDX_W];
  assign in_range = (bus.slave_address[VBUF_ADDR_W-1:VBUF_ADDR_LSB+VBUF_IDX_W] == '0)
                 && ({1'b0, word_idx} < DEPTH_LIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wait_req  = 1'b1;
    clearing  = 1'b0;
    case (state_q)
      CLEAR: begin
        clearing  = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = READY;
          clr_idx_d = '0;
        end
      end
      READY: wait_req = 1'b0;
      default: state_d = CLEAR;
    endcase
    // A clear pulse always (re)starts the sweep from word 0.
    if (clear_req) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end
  end

  assign rd_acc = bus.slave_read  & ~wait_req;
  assign wr_acc = bus.slave_write & ~wait_req;

  // Sweep owns the write port while stalled, so it never collides with bus writes.
  always_comb begin
    ram_we    = clearing | (wr_acc & in_range);
    ram_waddr = clearing ? clr_idx_q : word_idx;
    ram_be    = clearing ? 4'hF : bus.slave_byteenable;
    ram_wdata = clearing ? 32'h0 : bus.slave_writedata;
    ram_re    = rd_acc & ~wr_acc & in_range;
  end

  vertex_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (VBUF_IDX_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wbe   (ram_be),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_vld_d    = rd_acc & ~wr_acc;
    rd_ok_d     = in_range;
    rdv_d       = rd_vld_q;
    rdata_out_d = rdata_out_q;
    if (rd_vld_q) rdata_out_d = rd_ok_q ? ram_rdata : 32'h0;
    err_d = err_q;
    if ((rd_acc | wr_acc) && (!in_range || (rd_acc && wr_acc))) err_d = sat_inc8(err_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_vld_q    <= 1'b0;
      rd_ok_q     <= 1'b0;
      rdv_q       <= 1'b0;
      rdata_out_q <= '0;
      err_q       <= '0;
    end else begin
      rd_vld_q    <= rd_vld_d;
      rd_ok_q     <= rd_ok_d;
      rdv_q       <= rdv_d;
      rdata_out_q <= rdata_out_d;
      err_q       <= err_d;
    end
  end

  assign bus.slave_readdata      = rdata_out_q;
  assign bus.slave_readdatavalid = rdv_q;
  assign bus.slave_waitrequest   = wait_req;
  assign error_count             = err_q;

endmodule

// File: tb/tb_vertex_buffer_slave.sv
// Scoreboard bench for vertex_buffer_slave: stimulus pushes expected reads, a monitor pops them.
module tb_vertex_buffer_slave;
  import rasterizer_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear_req = 1'b0;
  logic [7:0] error_count;

  vertex_buffer_slave_if bus_if();

  vertex_buffer_slave #(.DEPTH_WORDS(256)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_if),
    .clear_req   (clear_req),
    .error_count (error_count)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (bus_if.slave_readdatavalid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_readdatavalid actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("rd_data", bus_if.slave_readdata, e.data);
          check("rd_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [25:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    @(negedge clock);
    bus_if.slave_read       = rd;
    bus_if.slave_write      = wr;
    bus_if.slave_address    = a;
    bus_if.slave_byteenable = be;
    bus_if.slave_writedata  = d;
  endtask

  task automatic rd_req(input logic [25:0] a, input logic [31:0] exp);
    exp_t e;
    drive(1'b1, 1'b0, a, 4'h0, 32'h0);
    e.data = exp;
    e.due  = cyc + VBUF_READ_LATENCY;
    sb.push_back(e);
  endtask

  task automatic wr_req(input logic [25:0] a, input logic [3:0] be, input logic [31:0] d);
    drive(1'b0, 1'b1, a, be, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 26'h0, 4'h0, 32'h0);
  endtask

  task automatic count_wait(output int n);
    n = 0;
    while (bus_if.slave_waitrequest === 1'b1 && n < 2000) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    bus_if.slave_read       = 1'b0;
    bus_if.slave_write      = 1'b0;
    bus_if.slave_address    = '0;
    bus_if.slave_byteenable = '0;
    bus_if.slave_writedata  = '0;

    repeat (3) @(negedge clock);
    check("rst_waitrequest", 32'(bus_if.slave_waitrequest), 32'd1);
    check("rst_readdatavalid", 32'(bus_if.slave_readdatavalid), 32'd0);
    check("rst_readdata", bus_if.slave_readdata, 32'h0);
    check("rst_error_count", 32'(error_count), 32'd0);

    @(negedge clock);
    reset = 1'b1;
    count_wait(n);
    check("clear_cycles_after_reset", 32'(n), 32'd256);

    rd_req(26'h14, 32'h0);

    wr_req(26'h0, 4'hF, 32'h10);
    wr_req(26'h4, 4'hF, 32'h20);
    wr_req(26'h8, 4'hF, 32'h30);
    rd_req(26'h0, 32'h10);
    rd_req(26'h4, 32'h20);
    rd_req(26'h8, 32'h30);
    idle(1);

    wr_req(26'h0, 4'hF, 32'h11223344);
    wr_req(26'h0, 4'b0011, 32'hAABBCCDD);
    rd_req(26'h0, 32'h1122CCDD);
    idle(1);

    rd_req(26'h9, 32'h30);
    rd_req(26'h6, 32'h20);
    idle(3);
    check("err_after_misaligned", 32'(error_count), 32'd0);

    rd_req(26'h400, 32'h0);
    idle(3);
    check("err_after_oor_read", 32'(error_count), 32'd1);

    drive(1'b1, 1'b1, 26'h8, 4'hF, 32'h55);
    idle(3);
    check("err_after_rd_wr", 32'(error_count), 32'd2);
    rd_req(26'h8, 32'h55);

    wr_req(26'h404, 4'hF, 32'hDEAD);
    idle(3);
    check("err_after_oor_write", 32'(error_count), 32'd3);
    rd_req(26'h4, 32'h20);
    idle(1);

    repeat (300) wr_req(26'h800, 4'hF, 32'hFFFFFFFF);
    idle(3);
    check("err_saturated", 32'(error_count), 32'd255);

    // In-flight reads must return pre-clear data.
    rd_req(26'h0, 32'h1122CCDD);
    rd_req(26'h8, 32'h55);
    idle(1);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    count_wait(n);
    check("clear_cycles_after_req", 32'(n), 32'd256);
    rd_req(26'h0, 32'h0);
    rd_req(26'h8, 32'h0);
    wr_req(26'h10, 4'hF, 32'hCAFEF00D);
    idle(1);

    // Restart the sweep 10 words in; 10 + 1 + 256 stalled cycles.
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    n = 0;
    while (bus_if.slave_waitrequest === 1'b1 && n < 2000) begin
      n++;
      @(negedge clock);
      clear_req = (n == 10);
    end
    clear_req = 1'b0;
    check("clear_restart_cycles", 32'(n), 32'd267);
    rd_req(26'h10, 32'h0);

    wr_req(26'h20, 4'hF, 32'h12345678);
    rd_req(26'h20, 32'h12345678);
    idle(1);

    // Read accepted, then reset in the following cycle: no response may appear.
    drive(1'b1, 1'b0, 26'h20, 4'h0, 32'h0);
    @(negedge clock);
    bus_if.slave_read = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_readdatavalid", 32'(bus_if.slave_readdatavalid), 32'd0);
    check("midrst_error_count", 32'(error_count), 32'd0);
    repeat (3) @(negedge clock);

    // Requests held during the post-reset sweep must be ignored.
    bus_if.slave_read       = 1'b1;
    bus_if.slave_write      = 1'b1;
    bus_if.slave_address    = 26'hC;
    bus_if.slave_byteenable = 4'hF;
    bus_if.slave_writedata  = 32'h77;
    reset = 1'b1;
    count_wait(n);
    bus_if.slave_read  = 1'b0;
    bus_if.slave_write = 1'b0;
    check("clear_cycles_after_midrst", 32'(n), 32'd256);
    check("err_after_stalled_reqs", 32'(error_count), 32'd0);
    rd_req(26'hC, 32'h0);
    rd_req(26'h20, 32'h0);
    idle(5);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vertex_buffer_slave.md
VERTEX_BUFFER_SLAVE -- requirements
Module: vertex_buffer_slave

Interface
REQ-001 Parameters: DEPTH_WORDS, default 256, number of 32-bit vertex words stored. READ_LATENCY is fixed at 2 and is not a parameter.
REQ-002 clock  input  1  system clock, all logic rising-edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 slave_address  input  26  byte address; word index = address[9:2].
REQ-005 slave_read  input  1  read request.
REQ-006 slave_write  input  1  write request.
REQ-007 slave_byteenable  input  4  per-byte write enable; ignored for reads.
REQ-008 slave_writedata  input  32  write data.
REQ-009 slave_readdata  output  32  read data, qualified by slave_readdatavalid.
REQ-010 slave_readdatavalid  output  1  one pulse per accepted read.
REQ-011 slave_waitrequest  output  1  high = request not accepted.
REQ-012 clear_req  input  1  single-cycle pulse; re-zeroes the whole buffer.
REQ-013 error_count  output  8  saturating count of out-of-range or illegal requests.

Function
REQ-014 The block SHALL be an Avalon-MM pipelined-read slave. It is the responder for the rasterizer vertex-fetch read master.
REQ-015 The state machine SHALL have two states, CLEAR and READY.
REQ-016 In CLEAR: writes zero to word clr_idx, increments clr_idx each cycle, holds waitrequest=1, and goes to READY after word DEPTH_WORDS-1 is written.
REQ-017 In READY, waitrequest SHALL be 0.
REQ-018 A request SHALL be accepted only in a cycle where it is asserted with waitrequest=0. Requests presented while waitrequest=1 have no effect and are not counted.
REQ-019 An accepted write SHALL update only the bytes whose byteenable bit is 1, and SHALL be visible to a read accepted in the following cycle.
REQ-020 A read accepted in cycle n SHALL return readdatavalid=1 with its data in cycle n+2.
REQ-021 Reads accepted back-to-back SHALL return back-to-back, in acceptance order. No bubbles SHALL be inserted.
REQ-022 readdatavalid SHALL be 0 in every cycle without a response. readdata is don't-care when valid=0 and SHALL hold its last value.
REQ-023 Out-of-range request (address[25:10] != 0, or word index >= DEPTH_WORDS):
- read SHALL still respond at n+2 with data 0x00000000;
- write SHALL be dropped;
- error_count SHALL increment.
REQ-024 read and write asserted together and accepted: the write SHALL take effect, the read SHALL be dropped (no readdatavalid), and error_count SHALL increment.
REQ-025 error_count SHALL saturate at 255 and SHALL never wrap.
REQ-026 clear_req in READY SHALL enter CLEAR next cycle with clr_idx=0. Reads already accepted SHALL still complete with pre-clear data.
REQ-027 clear_req during CLEAR SHALL restart clr_idx at 0.
REQ-028 Misaligned addresses (address[1:0] != 0) SHALL be treated as the word address[9:2] and SHALL not count as errors.

Reset
REQ-029 While reset=0:
- state=CLEAR, clr_idx=0;
- waitrequest=1;
- readdatavalid=0, readdata=0;
- error_count=0;
- all in-flight read pipeline valids=0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight reads: no readdatavalid after release for reads accepted before reset.
REQ-031 After reset release, a full CLEAR pass (DEPTH_WORDS cycles) SHALL precede the first accepted request.

Structure
REQ-032 Package rasterizer_pkg SHALL hold:
- the vbuf_state_t enum {CLEAR, READY};
- the VBUF_ADDR_LSB=2 constant;
- the VBUF_READ_LATENCY=2 constant.
REQ-033 Storage SHALL be a sub-module vertex_ram with:
- a simple dual-port, 32-bit, byte-enabled, one-cycle registered read;
- its write port shared between the CLEAR sweep and slave writes, with CLEAR having priority since waitrequest=1 then.
REQ-034 Read response SHALL use a two-stage valid/range-flag pipeline plus an output register. There SHALL be no FIFO.

Verification
REQ-035 Reset release -> waitrequest=1 for exactly 256 cycles, then 0; a read of word 5 then returns 0x00000000 at n+2.
REQ-036 Write 0x00000010/0x00000020/0x00000030 to byte addresses 0x0/0x4/0x8, then 3 back-to-back reads from cycle n -> readdatavalid in n+2, n+3, n+4 with 0x10, 0x20, 0x30 in order.
REQ-037 Write 0x11223344 to 0x0, then write 0xAABBCCDD with byteenable 4'b0011 -> read returns 0x1122CCDD.
REQ-038 Read address 0x400 -> response at n+2 with data 0x0 and error_count=1. Read and write together to 0x8 -> write applied, no response, error_count=2. 300 such errors -> error_count=255.
REQ-039 Issue 2 reads, assert clear_req in the cycle after the second read -> both responses carry old data and waitrequest=1 for 256 cycles. Separately, drop reset in cycle n+1 of a read -> no readdatavalid ever for that read.
